// File: rtl/mult_seq_pkg.sv
// Shared types, widths and step-to-shift mapping for the sequenced 8x8 multiplier.
package mult_seq_pkg;

    localparam int unsigned NIB_W     = 4;
    localparam int unsigned OP_W      = 8;
    localparam int unsigned P_W       = 16;
    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned CNT_W     = $clog2(NUM_STEPS);
    localparam int unsigned SH_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Partial-product weight for each issue step: {0,4,4,8}
    function automatic logic [SH_W-1:0] step_shift(input logic [CNT_W-1:0] step);
        case (step)
            2'd0:    return SH_W'(0);
            2'd1:    return SH_W'(4);
            2'd2:    return SH_W'(4);
            default: return SH_W'(8);
        endcase
    endfunction

endpackage

// File: rtl/pp_nibble_mult.sv
// Registered unsigned 4x4 nibble multiplier, one-cycle latency.
module pp_nibble_mult
    import mult_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [NIB_W-1:0]     a_i,
    input  logic [NIB_W-1:0]     b_i,
    output logic [2*NIB_W-1:0]   p_o
);

    logic [2*NIB_W-1:0] p_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) p_q <= '0;
        else        p_q <= (2*NIB_W)'(a_i) * (2*NIB_W)'(b_i);
    end

    assign p_o = p_q;

endmodule

// File: rtl/multi_8_8_seq_ctrl.sv
// 8x8 unsigned multiply sequenced over one shared 4x4 nibble multiplier.
// Optional macro MULT_ZERO_SKIP_EN: zero operands complete in one edge.
module multi_8_8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned OUT_HOLD = 1
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            start,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [P_W-1:0]  p
);

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [P_W-1:0]      acc_q, acc_d, p_q, p_d;
    logic                tag_vld_q, tag_vld_d;
    logic [SH_W-1:0]     tag_shift_q, tag_shift_d;
    logic                done_q, done_d, busy_q, busy_d;

    logic [NIB_W-1:0]    nib_a_c, nib_b_c;
    logic [2*NIB_W-1:0]  pp_c;
    logic [P_W-1:0]      pp_shift_c;
    logic                skip_c;

    // Step bit 1 selects the high multiplicand nibble, bit 0 the high multiplier nibble
    assign nib_a_c    = cnt_q[1] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
    assign nib_b_c    = cnt_q[0] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
    assign pp_shift_c = P_W'(pp_c) << tag_shift_q;
    assign skip_c     = ZERO_SKIP && ((a == '0) || (b == '0));

    pp_nibble_mult u_mult (
        .clk   (clk),
        .clr_n (clr_n),
        .a_i   (nib_a_c),
        .b_i   (nib_b_c),
        .p_o   (pp_c)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            tag_vld_q   <= 1'b0;
            tag_shift_q <= '0;
            p_q         <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            tag_vld_q   <= tag_vld_d;
            tag_shift_q <= tag_shift_d;
            p_q         <= p_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !skip_c) state_d = ISSUE;
            ISSUE:   if (cnt_q == LAST_STEP) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the shift tag travels with the multiplier's one-cycle latency
    always_comb begin
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        tag_vld_d   = 1'b0;
        tag_shift_d = tag_shift_q;
        p_d         = p_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (skip_c) begin
                        p_d    = '0;
                        done_d = 1'b1;
                    end else begin
                        a_d    = a;
                        b_d    = b;
                        cnt_d  = '0;
                        acc_d  = '0;
                        busy_d = 1'b1;
                        if (OUT_HOLD == 0) p_d = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d       = CNT_W'(cnt_q + CNT_W'(1));
                tag_vld_d   = 1'b1;
                tag_shift_d = step_shift(cnt_q);
                if (tag_vld_q) acc_d = acc_q + pp_shift_c;
            end
            DRAIN: begin
                p_d    = acc_q + pp_shift_c;
                done_d = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign p    = p_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_multi_8_8_seq_ctrl.sv
// Directed bench for multi_8_8_seq_ctrl with hand-computed products.
module tb_multi_8_8_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int tests = 0;
    int fails = 0;

    multi_8_8_seq_ctrl dut (
        .clk   (clk),
        .clr_n (clr_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Issues one op from the current cycle; returns positioned in the done cycle
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                          input logic [15:0] exp_p, input logic [15:0] hold_p,
                          input string tag);
        start = 1'b1;
        a = ai;
        b = bi;
        step();
        start = 1'b0;
        a = ~ai;
        b = ~bi;
        chk_b({tag, "_busy_k"}, busy, 1'b1);
        chk_b({tag, "_done_k"}, done, 1'b0);
        chk({tag, "_hold_k"}, p, hold_p);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_b({tag, "_busy_mid"}, busy, 1'b1);
            chk_b({tag, "_done_mid"}, done, 1'b0);
        end
        chk({tag, "_hold_k4"}, p, hold_p);
        step();
        chk_b({tag, "_done"}, done, 1'b1);
        chk_b({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_p"}, p, exp_p);
    endtask

    initial begin
        int ndone;

        // Reset state
        #2;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk("rst_p", p, 16'h0000);
        step();
        step();
        clr_n = 1'b1;
        step();
        chk_b("idle_busy", busy, 1'b0);

        // Basic product
        run_op(8'h12, 8'h34, 16'h03A8, 16'h0000, "t1");
        step();
        chk_b("t1_done_one_cycle", done, 1'b0);
        chk("t1_p_hold", p, 16'h03A8);

        // Max operands, then back-to-back start in the done cycle
        run_op(8'hFF, 8'hFF, 16'hFE01, 16'h03A8, "t2a");
        run_op(8'hA5, 8'h5A, 16'h3A02, 16'hFE01, "t2b");
        step();
        chk_b("t2_idle_done", done, 1'b0);
        chk_b("t2_idle_busy", busy, 1'b0);

        // Start held high: one result every 6 cycles, operand churn ignored
        start = 1'b1;
        a = 8'h0F;
        b = 8'h10;
        for (int r = 0; r < 2; r++) begin
            step();
            chk_b("t3_accept_busy", busy, 1'b1);
            a = 8'($urandom);
            b = 8'($urandom);
            for (int i = 1; i <= 4; i++) begin
                step();
                chk_b("t3_busy_mid", busy, 1'b1);
            end
            step();
            chk_b("t3_done", done, 1'b1);
            chk("t3_p", p, 16'h00F0);
            a = 8'h0F;
            b = 8'h10;
        end
        start = 1'b0;
        step();
        chk_b("t3_no_reaccept", busy, 1'b0);

        // Start during ISSUE is ignored, single done with original result
        start = 1'b1;
        a = 8'h21;
        b = 8'h13;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        step();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (done) ndone++;
        end
        chk("t4_done_count", 16'(ndone), 16'd1);
        chk("t4_p", p, 16'h0273);
        chk_b("t4_busy", busy, 1'b0);

        // Reset mid-operation aborts
        start = 1'b1;
        a = 8'h44;
        b = 8'h44;
        step();
        start = 1'b0;
        step();
        step();
        clr_n = 1'b0;
        #1;
        chk("t5_rst_p", p, 16'h0000);
        chk_b("t5_rst_busy", busy, 1'b0);
        chk_b("t5_rst_done", done, 1'b0);
        step();
        step();
        clr_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) ndone++;
        end
        chk("t5_no_activity", 16'(ndone), 16'd0);
        run_op(8'h03, 8'h07, 16'h0015, 16'h0000, "t5b");
        step();

        // Zero operand
`ifdef MULT_ZERO_SKIP_EN
        start = 1'b1;
        a = 8'h00;
        b = 8'h9C;
        step();
        start = 1'b0;
        chk_b("t6_done", done, 1'b1);
        chk_b("t6_busy", busy, 1'b0);
        chk("t6_p", p, 16'h0000);
        step();
        chk_b("t6_done_clear", done, 1'b0);
        chk_b("t6_busy_after", busy, 1'b0);
`else
        run_op(8'h00, 8'h9C, 16'h0000, 16'h0015, "t6");
        step();
        chk_b("t6_done_clear", done, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
